// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and the buffered fetch entry type for the fetch front end
package fetch_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
   localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return {a[XLEN-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry FIFO of fetched {instr, pc} pairs with synchronous flush
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  fetch_entry_t  push_data_i,
   input  logic          pop_i,
   input  logic          flush_i,
   output fetch_entry_t  head_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   fetch_entry_t  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];
   assign do_pop  = pop_i && !empty_o;
   // A full FIFO may still take a push when its head leaves in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end: PC, in-order memory requests, redirect flush
// FETCH_PERF_EN builds the saturating FetchCnt/StallCnt/FlushCnt counters; otherwise they read 0.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  StallF,
   input  logic                  Redirect,
   input  logic [DATA_WIDTH-1:0] RedirectPC,
   output logic                  ReqValid,
   output logic [DATA_WIDTH-1:0] ReqAddr,
   input  logic                  ReqReady,
   input  logic                  RespValid,
   input  logic [DATA_WIDTH-1:0] RespData,
   output logic [DATA_WIDTH-1:0] RD,
   output logic [DATA_WIDTH-1:0] PCF,
   output logic [DATA_WIDTH-1:0] PC_PlusF,
   output logic                  ValidF,
   output logic [31:0]           FetchCnt,
   output logic [31:0]           StallCnt,
   output logic [31:0]           FlushCnt
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, pcf_q;
   logic [CW-1:0]         outst_q, outst_d, stale_q, stale_d, fifo_count;
   logic [CW:0]           occupancy;
   fetch_entry_t          head, push_entry;
   logic                  fifo_empty, unused_fifo_full;
   logic                  accept, resp_dec, push, pop;

   // Credit covers both buffered words and requests still in flight, so the FIFO cannot overflow.
   assign occupancy  = {1'b0, outst_q} + {1'b0, fifo_count};
   assign ReqValid   = !rst && !Redirect && (occupancy < (CW+1)'(DEPTH));
   assign ReqAddr    = fetch_pc_q;
   assign accept     = ReqValid && ReqReady;
   assign resp_dec   = RespValid && (outst_q != '0);
   assign push       = resp_dec && !Redirect && (stale_q == '0);
   assign push_entry = '{instr: RespData, pc: resp_pc_q};

   assign ValidF   = !fifo_empty;
   assign pop      = ValidF && !StallF;
   assign RD       = ValidF ? head.instr : NOP_INSTR;
   assign PCF      = ValidF ? head.pc : pcf_q;
   assign PC_PlusF = PCF + PC_STEP;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (Redirect),
      .head_o      (head),
      .count_o     (fifo_count),
      .full_o      (unused_fifo_full),
      .empty_o     (fifo_empty)
   );

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      outst_d    = outst_q;
      stale_d    = stale_q;
      if (Redirect) begin
         // Everything still in flight after this cycle belongs to the abandoned path.
         outst_d    = outst_q - CW'(resp_dec);
         stale_d    = outst_q - CW'(resp_dec);
         fetch_pc_d = word_align(RedirectPC);
         resp_pc_d  = word_align(RedirectPC);
      end else begin
         outst_d = outst_q + CW'(accept) - CW'(resp_dec);
         if (accept) fetch_pc_d = fetch_pc_q + PC_STEP;
         if (resp_dec && (stale_q != '0)) stale_d = stale_q - 1'b1;
         if (push) resp_pc_d = resp_pc_q + PC_STEP;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         outst_q    <= '0;
         stale_q    <= '0;
         pcf_q      <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         resp_pc_q  <= resp_pc_d;
         outst_q    <= outst_d;
         stale_q    <= stale_d;
         if (ValidF) pcf_q <= head.pc;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (pop && (fetch_cnt_q != '1))                 fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (ValidF && StallF && (stall_cnt_q != '1))    stall_cnt_q <= stall_cnt_q + 32'd1;
         if (Redirect && (flush_cnt_q != '1))            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign FetchCnt = fetch_cnt_q;
   assign StallCnt = stall_cnt_q;
   assign FlushCnt = flush_cnt_q;
`else
   assign FetchCnt = 32'h0;
   assign StallCnt = 32'h0;
   assign FlushCnt = 32'h0;
`endif
endmodule
